// File: rtl/led_sequencer.sv
// led_sequencer: prescaled LED pattern generator (rotate left/right, bounce, fill).
// A DIV_WIDTH-bit prescaler produces one step every 2^DIV_WIDTH enabled cycles.
// On each step the selected pattern advances, or reloads its seed if the mode changed.
// o_stb pulses in the cycle the newly stepped pattern appears on o_led.
// Optional build macro LED_PWM_EN adds a 4-bit brightness input (i_bright).
// It also adds a free-running 16-cycle PWM that gates o_led.
// The default build (LED_PWM_EN undefined) drives o_led straight from the pattern register.
module led_sequencer #(
  parameter int NLEDS     = 4,
  parameter int DIV_WIDTH = 25
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
`ifdef LED_PWM_EN
  input  logic [3:0]       i_bright,
`endif
  output logic [NLEDS-1:0] o_led,
  output logic             o_stb
);

  typedef enum logic [1:0] {
    MODE_ROTL   = 2'b00,
    MODE_ROTR   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_FILL   = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam logic [NLEDS-1:0]     LED_LSB = {{(NLEDS-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0] CNT_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  logic [DIV_WIDTH-1:0] cnt_reg;
  logic [NLEDS-1:0]     pattern_reg;
  mode_t                cur_mode_reg;
  dir_t                 dir_reg;
  logic                 stb_reg;

  logic                 step;
  mode_t                mode_in;
  logic [NLEDS-1:0]     seed_next;
  logic [NLEDS-1:0]     rotl_next;
  logic [NLEDS-1:0]     rotr_next;
  logic [NLEDS-1:0]     shl_next;
  logic [NLEDS-1:0]     shr_next;
  logic [NLEDS-1:0]     fill_next;

  // A step happens only on an enabled edge where the prescaler is about to wrap.
  assign step    = i_en && (cnt_reg == {DIV_WIDTH{1'b1}});
  assign mode_in = mode_t'(i_mode);

  // Candidate next patterns; all are exactly NLEDS wide so nothing falls off the ends.
  assign rotl_next = {pattern_reg[NLEDS-2:0], pattern_reg[NLEDS-1]};
  assign rotr_next = {pattern_reg[0], pattern_reg[NLEDS-1:1]};
  assign shl_next  = {pattern_reg[NLEDS-2:0], 1'b0};
  assign shr_next  = {1'b0, pattern_reg[NLEDS-1:1]};
  assign fill_next = (&pattern_reg) ? {NLEDS{1'b0}} : {pattern_reg[NLEDS-2:0], 1'b1};

  // Seed loaded when the mode changes: FILL starts dark, all others start at the LSB LED.
  // Seeding keeps the rotate modes one-hot even after leaving FILL.
  assign seed_next = (mode_in == MODE_FILL) ? {NLEDS{1'b0}} : LED_LSB;

  // Prescaler, mode tracking, bounce direction FSM and pattern register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_reg      <= {DIV_WIDTH{1'b0}};
      pattern_reg  <= LED_LSB;
      cur_mode_reg <= MODE_ROTL;
      dir_reg      <= DIR_LEFT;
      stb_reg      <= 1'b0;
    end else begin
      stb_reg <= step;
      if (i_en) begin
        cnt_reg <= cnt_reg + CNT_ONE;
      end
      if (step) begin
        if (mode_in != cur_mode_reg) begin
          // A mode change spends its step on the reload and does not advance the pattern.
          cur_mode_reg <= mode_in;
          pattern_reg  <= seed_next;
          dir_reg      <= DIR_LEFT;
        end else begin
          unique case (cur_mode_reg)
            MODE_ROTL: pattern_reg <= rotl_next;
            MODE_ROTR: pattern_reg <= rotr_next;
            MODE_BOUNCE: begin
              // Reverse on reaching an end, so each end LED is lit for a single step.
              unique case (dir_reg)
                DIR_LEFT: begin
                  if (pattern_reg[NLEDS-1]) begin
                    dir_reg     <= DIR_RIGHT;
                    pattern_reg <= shr_next;
                  end else begin
                    pattern_reg <= shl_next;
                  end
                end
                DIR_RIGHT: begin
                  if (pattern_reg[0]) begin
                    dir_reg     <= DIR_LEFT;
                    pattern_reg <= shl_next;
                  end else begin
                    pattern_reg <= shr_next;
                  end
                end
                default: dir_reg <= DIR_LEFT;
              endcase
            end
            MODE_FILL: pattern_reg <= fill_next;
            default:   pattern_reg <= LED_LSB;
          endcase
        end
      end
    end
  end

  assign o_stb = stb_reg;

`ifdef LED_PWM_EN
  logic [3:0] pwm_cnt_reg;
  logic       pwm_on;

  // Free-running brightness counter; deliberately ignores i_en so a frozen pattern still dims.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pwm_cnt_reg <= 4'd0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + 4'd1;
    end
  end

  // Lit for i_bright out of every 16 cycles; i_bright = 0 keeps every LED dark.
  assign pwm_on = (pwm_cnt_reg < i_bright);

  genvar gi;
  generate
    for (gi = 0; gi < NLEDS; gi++) begin : g_led_pwm
      assign o_led[gi] = pattern_reg[gi] & pwm_on;
    end
  endgenerate
`else
  genvar gi;
  generate
    for (gi = 0; gi < NLEDS; gi++) begin : g_led_out
      assign o_led[gi] = pattern_reg[gi];
    end
  endgenerate
`endif

endmodule
